msync_sched: RTL and testbench
==============================

Name: msync_sched

Overview:
- Master-sync scheduler for the channel datapath; replaces the free-running test counter that drives msync_n.
- Selects one trigger source: internal period timer, wheel quadrature encoder (adp/bdp) or external RS422 sync.
- Enforces a minimum repetition interval and waits for all four data channels to finish their cycle.
- Emits one active-low msync_n pulse per accepted trigger, plus counters and status for the host.

Parameters:
- PW_CYC, 4: msync_n low width in clk cycles; 200 ns at 20 MHz, above the 80 ns minimum.
- SYNC_STAGES, 2: synchronizer depth for asynchronous inputs.
- CMPL_TMO, 16'd50000: channel-complete wait timeout in clk cycles; 2.5 ms at 20 MHz.

Ports:
- clk  in  1  clk20 channel master clock; all logic in this domain
- rst  in  1  asynchronous active-high reset
- cfg_mode  in  2  0=off, 1=internal timer, 2=wheel, 3=external sync
- cfg_period  in  24  internal period in clk cycles; 0 is treated as off
- cfg_min_gap  in  24  minimum clk cycles between msync falling edges
- cfg_wheel_div  in  8  encoder steps per trigger; 0 is treated as 1
- cfg_wheel_dir  in  1  0=forward steps trigger, 1=reverse steps trigger
- i_adp  in  1  encoder phase A, asynchronous
- i_bdp  in  1  encoder phase B, asynchronous
- i_sync  in  1  external sync, asynchronous; rising edge is the trigger
- i_chan_cmpl  in  4  per-channel end-of-cycle level, clk domain
- o_msync_n  out  1  master sync, active low
- o_sync_cnt  out  16  accepted syncs; wraps
- o_wheel_pos  out  32  signed encoder position, x4 decoding
- o_overrun  out  1  sticky flag: a trigger was dropped
- i_clr_ovr  in  1  one-cycle pulse; clears o_overrun

Behaviour:
- Reset values: o_msync_n=1, o_sync_cnt=0, o_wheel_pos=0, o_overrun=0, FSM=IDLE, pending=0, all counters 0.
- Inputs: i_adp, i_bdp and i_sync pass through SYNC_STAGES flops. Edges are detected on the synchronized values.
- Quadrature decoding: a valid Gray transition does ±1 on o_wheel_pos (A leads B = +1). A double-bit change is illegal: ignored, position unchanged. o_wheel_pos wraps in two's complement.
- Wheel trigger: a step counter counts steps in the selected direction only. Steps in the opposite direction decrement it, saturating at 0. When it reaches cfg_wheel_div it resets to 0 and fires one trigger.
- Timer trigger: the counter fires when it reaches cfg_period-1, then reloads 0. It runs only in mode 1.
- Mode change: any change of cfg_mode clears the timer counter, the step counter and pending. An in-flight PULSE completes.
- Trigger arbitration: at most one trigger per cycle, from the selected source only. An accepted trigger sets pending. A trigger arriving while pending=1 is dropped and sets o_overrun.
- FSM states: IDLE, PULSE, GAP, WAITC.
  - IDLE: if pending=1, go to PULSE next cycle and clear pending. o_msync_n goes low on entry to PULSE, so trigger-to-msync latency is 1 clk after pending is set.
  - PULSE: o_msync_n=0 for exactly PW_CYC cycles, then GAP. o_sync_cnt increments on PULSE entry. The gap counter starts at PULSE entry.
  - GAP: leave when the gap counter is ≥ cfg_min_gap-1 (cfg_min_gap=0 means no wait), then go to WAITC.
  - WAITC: latch the i_chan_cmpl bits seen since PULSE entry (OR-accumulate). Return to IDLE when all 4 are set or after CMPL_TMO cycles. A timeout sets o_overrun.
- Triggers are accepted into pending during PULSE, GAP and WAITC. They are never issued as msync before IDLE.
- i_clr_ovr and a new overrun in the same cycle: set wins.
- cfg_mode=0: no triggers are generated. A pending trigger is cleared; o_wheel_pos still tracks the encoder.
- rst mid-pulse: o_msync_n returns to 1 immediately (asynchronous).

Decomposition:
- Shared package: mode encodings (MODE_OFF, MODE_TIMER, MODE_WHEEL, MODE_EXT), FSM state typedef, PW_CYC default.
- Sub-module quad_dec: synchronizers, x4 decoding, position counter and step/dir outputs. The top level keeps trigger generation, the FSM and status.

Test Plan:
- Mode 1, period=1000, min_gap=0, cmpl all 1 -> o_msync_n low 4 cycles every 1000 cycles; o_sync_cnt=5 after 5000 cycles.
- Mode 2, div=4, dir=0, 10 forward steps -> 2 msync pulses; o_wheel_pos=10. Then 3 reverse steps -> no pulse; pos=7.
- Mode 3, i_sync edges 10 cycles apart, min_gap=100 -> first pulses; second pending, issued at gap end; third arrives while pending -> dropped, o_overrun=1.
- Mode 1, period=200, i_chan_cmpl stuck 4'b0111 -> each cycle waits 50000 cycles (CMPL_TMO) then continues; o_overrun=1; i_clr_ovr clears it.
- Illegal AB jump 00→11 -> o_wheel_pos unchanged, no trigger.
- rst asserted 2 cycles into PULSE -> o_msync_n=1 same cycle; all counters 0; after release, first timer pulse after cfg_period cycles.

Source files
------------

// File: rtl/msync_sched_pkg.sv
// Shared definitions for the master-sync scheduler: trigger source modes,
// scheduler states and the default msync_n pulse width.
package msync_sched_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_TIMER = 2'd1;
    localparam logic [1:0] MODE_WHEEL = 2'd2;
    localparam logic [1:0] MODE_EXT   = 2'd3;

    localparam int unsigned PW_CYC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_WAITC
    } state_t;

endpackage

// File: rtl/msync_sched_quad_dec.sv
// Input synchronizers, x4 quadrature decoder with signed position counter,
// and rising-edge detection of the external sync.
module quad_dec #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adp_i,
    input  logic        bdp_i,
    input  logic        sync_i,
    output logic        step_fwd_o,
    output logic        step_rev_o,
    output logic        sync_rise_o,
    output logic [31:0] pos_o
);

    logic [SYNC_STAGES-1:0] a_sq, b_sq, s_sq;
    logic                   a_prev_q, b_prev_q, s_prev_q;
    logic [31:0]            pos_q, pos_d;
    logic                   a_now, b_now, s_now;
    logic                   step_fwd, step_rev;

    assign a_now = a_sq[SYNC_STAGES-1];
    assign b_now = b_sq[SYNC_STAGES-1];
    assign s_now = s_sq[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sq     <= '0;
            b_sq     <= '0;
            s_sq     <= '0;
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
            s_prev_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            a_sq     <= SYNC_STAGES'({a_sq, adp_i});
            b_sq     <= SYNC_STAGES'({b_sq, bdp_i});
            s_sq     <= SYNC_STAGES'({s_sq, sync_i});
            a_prev_q <= a_now;
            b_prev_q <= b_now;
            s_prev_q <= s_now;
            pos_q    <= pos_d;
        end
    end

    // {prev A,B, now A,B}; forward Gray order is 00->10->11->01, double-bit jumps fall to default
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        case ({a_prev_q, b_prev_q, a_now, b_now})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: step_fwd = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: step_rev = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pos_d = pos_q;
        if (step_fwd)      pos_d = pos_q + 32'd1;
        else if (step_rev) pos_d = pos_q - 32'd1;
    end

    assign step_fwd_o  = step_fwd;
    assign step_rev_o  = step_rev;
    assign sync_rise_o = s_now & ~s_prev_q;
    assign pos_o       = pos_q;

endmodule

// File: rtl/msync_sched.sv
// Master-sync scheduler: picks one trigger source, enforces the minimum gap and
// channel completion, and emits one active-low msync_n pulse per accepted trigger.
module msync_sched
    import msync_sched_pkg::*;
#(
    parameter int unsigned PW_CYC      = PW_CYC_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] CMPL_TMO    = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cfg_mode,
    input  logic [23:0] cfg_period,
    input  logic [23:0] cfg_min_gap,
    input  logic [7:0]  cfg_wheel_div,
    input  logic        cfg_wheel_dir,
    input  logic        i_adp,
    input  logic        i_bdp,
    input  logic        i_sync,
    input  logic [3:0]  i_chan_cmpl,
    output logic        o_msync_n,
    output logic [15:0] o_sync_cnt,
    output logic [31:0] o_wheel_pos,
    output logic        o_overrun,
    input  logic        i_clr_ovr
);

    localparam int unsigned     PW_W    = (PW_CYC > 1) ? $clog2(PW_CYC) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PW_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [23:0]       tmr_q, tmr_d;
    logic [7:0]        stepc_q, stepc_d;
    logic              pending_q, pending_d;
    logic [PW_W-1:0]   pw_q, pw_d;
    logic [23:0]       gap_q, gap_d;
    logic [3:0]        acc_q, acc_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ovr_q, ovr_d;

    logic              step_fwd, step_rev, sync_rise;
    logic              mode_chg, tmr_fire, wheel_fire, trig, ovr_set;
    logic              sel_step, opp_step;
    logic [7:0]        div_eff;
    logic [3:0]        acc_now;

    quad_dec #(.SYNC_STAGES(SYNC_STAGES)) u_quad (
        .clk         (clk),
        .rst         (rst),
        .adp_i       (i_adp),
        .bdp_i       (i_bdp),
        .sync_i      (i_sync),
        .step_fwd_o  (step_fwd),
        .step_rev_o  (step_rev),
        .sync_rise_o (sync_rise),
        .pos_o       (o_wheel_pos)
    );

    assign mode_chg = (cfg_mode != mode_q);

    always_comb begin
        tmr_fire = 1'b0;
        tmr_d    = '0;
        if (!mode_chg && cfg_mode == MODE_TIMER && cfg_period != '0) begin
            if (({1'b0, tmr_q} + 25'd1) >= {1'b0, cfg_period}) tmr_fire = 1'b1;
            else                                               tmr_d    = tmr_q + 24'd1;
        end
    end

    assign div_eff  = (cfg_wheel_div == '0) ? 8'd1 : cfg_wheel_div;
    assign sel_step = cfg_wheel_dir ? step_rev : step_fwd;
    assign opp_step = cfg_wheel_dir ? step_fwd : step_rev;

    always_comb begin
        wheel_fire = 1'b0;
        stepc_d    = '0;
        if (!mode_chg && cfg_mode == MODE_WHEEL) begin
            stepc_d = stepc_q;
            if (sel_step) begin
                if (({1'b0, stepc_q} + 9'd1) >= {1'b0, div_eff}) begin
                    wheel_fire = 1'b1;
                    stepc_d    = '0;
                end else begin
                    stepc_d = stepc_q + 8'd1;
                end
            end else if (opp_step && stepc_q != '0) begin
                stepc_d = stepc_q - 8'd1;
            end
        end
    end

    always_comb begin
        trig = 1'b0;
        if (!mode_chg) begin
            case (cfg_mode)
                MODE_TIMER: trig = tmr_fire;
                MODE_WHEEL: trig = wheel_fire;
                MODE_EXT:   trig = sync_rise;
                default:    trig = 1'b0;
            endcase
        end
    end

    assign acc_now = acc_q | i_chan_cmpl;

    always_comb begin
        state_d   = state_q;
        pw_d      = pw_q;
        gap_d     = gap_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovr_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && !mode_chg && cfg_mode != MODE_OFF) begin
                    state_d   = ST_PULSE;
                    pending_d = 1'b0;
                    pw_d      = '0;
                    gap_d     = '0;
                    acc_d     = '0;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            ST_PULSE: begin
                acc_d = acc_now;
                pw_d  = pw_q + PW_W'(1);
                if (gap_q != '1) gap_d = gap_q + 24'd1;
                if (pw_q == PW_LAST) state_d = ST_GAP;
            end
            ST_GAP: begin
                acc_d = acc_now;
                if (({1'b0, gap_q} + 25'd1) >= {1'b0, cfg_min_gap}) begin
                    state_d = ST_WAITC;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + 24'd1;
                end
            end
            ST_WAITC: begin
                acc_d = acc_now;
                if (&acc_now) begin
                    state_d = ST_IDLE;
                end else if (({1'b0, tmo_q} + 17'd1) >= {1'b0, CMPL_TMO}) begin
                    state_d = ST_IDLE;
                    ovr_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A trigger seen while one is already pending is lost, even if IDLE consumes it now
        if (mode_chg || cfg_mode == MODE_OFF) begin
            pending_d = 1'b0;
        end else if (trig) begin
            if (pending_q) ovr_set   = 1'b1;
            else           pending_d = 1'b1;
        end

        ovr_d = ovr_q;
        if (i_clr_ovr) ovr_d = 1'b0;
        if (ovr_set)   ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            tmr_q     <= '0;
            stepc_q   <= '0;
            pending_q <= 1'b0;
            pw_q      <= '0;
            gap_q     <= '0;
            acc_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= cfg_mode;
            tmr_q     <= tmr_d;
            stepc_q   <= stepc_d;
            pending_q <= pending_d;
            pw_q      <= pw_d;
            gap_q     <= gap_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_msync_n  = (state_q != ST_PULSE);
    assign o_sync_cnt = cnt_q;
    assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_msync_sched.sv
// Self-checking bench for msync_sched: randomized per-feature scenarios checked
// against pulse timing and counts derived from the scheduling rules.
module tb_msync_sched;

    localparam logic [15:0] TMO = 16'd3000;
    localparam int          PW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_period;
    logic [23:0] cfg_min_gap;
    logic [7:0]  cfg_wheel_div;
    logic        cfg_wheel_dir;
    logic        i_adp, i_bdp, i_sync;
    logic [3:0]  i_chan_cmpl;
    logic        i_clr_ovr;
    logic        o_msync_n;
    logic [15:0] o_sync_cnt;
    logic [31:0] o_wheel_pos;
    logic        o_overrun;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int   fall_q[$];
    int   width_q[$];
    logic prev_n  = 1'b1;
    int   low_cnt = 0;

    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         enc_idx;
    int         exp_pos;

    msync_sched #(.CMPL_TMO(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_mode      (cfg_mode),
        .cfg_period    (cfg_period),
        .cfg_min_gap   (cfg_min_gap),
        .cfg_wheel_div (cfg_wheel_div),
        .cfg_wheel_dir (cfg_wheel_dir),
        .i_adp         (i_adp),
        .i_bdp         (i_bdp),
        .i_sync        (i_sync),
        .i_chan_cmpl   (i_chan_cmpl),
        .o_msync_n     (o_msync_n),
        .o_sync_cnt    (o_sync_cnt),
        .o_wheel_pos   (o_wheel_pos),
        .o_overrun     (o_overrun),
        .i_clr_ovr     (i_clr_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle of every msync_n falling edge and the width of every completed pulse
    always @(negedge clk) begin
        if (rst) begin
            prev_n  = 1'b1;
            low_cnt = 0;
        end else begin
            if (o_msync_n === 1'b0) begin
                if (prev_n === 1'b1) fall_q.push_back(cyc);
                low_cnt = low_cnt + 1;
            end else if (prev_n === 1'b0) begin
                width_q.push_back(low_cnt);
                low_cnt = 0;
            end
            prev_n = o_msync_n;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_mode = 2'd0; cfg_period = '0; cfg_min_gap = '0;
        cfg_wheel_div = '0; cfg_wheel_dir = 1'b0;
        i_adp = 1'b0; i_bdp = 1'b0; i_sync = 1'b0;
        i_chan_cmpl = 4'hF; i_clr_ovr = 1'b0;
        enc_idx = 0; exp_pos = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic enc_step(input bit fwd);
        enc_idx = fwd ? (enc_idx + 1) % 4 : (enc_idx + 3) % 4;
        {i_adp, i_bdp} = seq[enc_idx];
        exp_pos = fwd ? exp_pos + 1 : exp_pos - 1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (o_msync_n !== 1'b1) $display("FAIL reset_msync: got %b want 1", o_msync_n); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", o_sync_cnt); else n_pass++;
        n_total++; if (o_wheel_pos !== 32'd0) $display("FAIL reset_pos: got %0d want 0", o_wheel_pos); else n_pass++;
        n_total++; if (o_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", o_overrun); else n_pass++;
        do_reset();
        repeat (5) @(negedge clk);
        n_total++; if (o_msync_n !== 1'b1) $display("FAIL idle_msync: got %b want 1", o_msync_n); else n_pass++;
    endtask

    task automatic test_timer(input int p, input int n);
        int t0, nf0, nw0, got, want;
        do_reset();
        nf0 = fall_q.size(); nw0 = width_q.size();
        cfg_period = 24'(p);
        cfg_mode   = 2'd1;
        t0 = cyc;
        repeat (p * n + 10) @(negedge clk);
        n_total++; if (fall_q.size() - nf0 != n) $display("FAIL timer_npulse: got %0d want %0d", fall_q.size() - nf0, n); else n_pass++;
        for (int k = 0; k < n; k++) begin
            want = t0 + p + 2 + k * p;
            got  = (nf0 + k < fall_q.size()) ? fall_q[nf0 + k] : -1;
            n_total++; if (got != want) $display("FAIL timer_fall%0d: got %0d want %0d", k, got, want); else n_pass++;
            got  = (nw0 + k < width_q.size()) ? width_q[nw0 + k] : -1;
            n_total++; if (got != PW) $display("FAIL timer_width%0d: got %0d want %0d", k, got, PW); else n_pass++;
        end
        n_total++; if (o_sync_cnt !== 16'(n)) $display("FAIL timer_cnt: got %0d want %0d", o_sync_cnt, n); else n_pass++;
        n_total++; if (o_overrun !== 1'b0) $display("FAIL timer_ovr: got %b want 0", o_overrun); else n_pass++;
    endtask

    task automatic test_wheel_plan();
        int nf0;
        do_reset();
        nf0 = fall_q.size();
        cfg_wheel_div = 8'd4; cfg_wheel_dir = 1'b0; cfg_mode = 2'd2;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 10; k++) enc_step(1'b1);
        n_total++; if (o_wheel_pos !== 32'd10) $display("FAIL wheel_pos10: got %0d want 10", o_wheel_pos); else n_pass++;
        n_total++; if (fall_q.size() - nf0 != 2) $display("FAIL wheel_npulse: got %0d want 2", fall_q.size() - nf0); else n_pass++;
        for (int k = 0; k < 3; k++) enc_step(1'b0);
        n_total++; if (o_wheel_pos !== 32'd7) $display("FAIL wheel_pos7: got %0d want 7", o_wheel_pos); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd2) $display("FAIL wheel_cnt: got %0d want 2", o_sync_cnt); else n_pass++;
    endtask

    task automatic test_wheel_random();
        int nf0, nw0, div, divm, steps, ntrig, bad_w;
        bit dir, sel;
        do_reset();
        nf0 = fall_q.size(); nw0 = width_q.size();
        div  = $urandom_range(0, 5);
        dir  = 1'($urandom_range(0, 1));
        divm = (div == 0) ? 1 : div;
        cfg_wheel_div = 8'(div); cfg_wheel_dir = dir; cfg_mode = 2'd2;
        repeat (3) @(negedge clk);
        steps = 0; ntrig = 0;
        for (int k = 0; k < 40; k++) begin
            sel = ($urandom_range(0, 3) != 0);
            enc_step(sel ^ dir);
            if (sel) begin
                steps++;
                if (steps == divm) begin steps = 0; ntrig++; end
            end else if (steps > 0) begin
                steps--;
            end
        end
        n_total++; if (o_wheel_pos !== 32'(exp_pos)) $display("FAIL wrand_pos: got %0d want %0d", $signed(o_wheel_pos), exp_pos); else n_pass++;
        n_total++; if (fall_q.size() - nf0 != ntrig) $display("FAIL wrand_npulse: got %0d want %0d", fall_q.size() - nf0, ntrig); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'(ntrig)) $display("FAIL wrand_cnt: got %0d want %0d", o_sync_cnt, ntrig); else n_pass++;
        bad_w = 0;
        for (int k = nw0; k < width_q.size(); k++) if (width_q[k] != PW) bad_w++;
        n_total++; if (bad_w != 0) $display("FAIL wrand_width: got %0d bad widths want 0", bad_w); else n_pass++;
    endtask

    task automatic test_illegal_jump();
        int nf0;
        do_reset();
        nf0 = fall_q.size();
        cfg_wheel_div = 8'd1; cfg_mode = 2'd2;
        repeat (3) @(negedge clk);
        {i_adp, i_bdp} = 2'b11; enc_idx = 2;
        repeat (12) @(negedge clk);
        n_total++; if (o_wheel_pos !== 32'd0) $display("FAIL jump_pos: got %0d want 0", o_wheel_pos); else n_pass++;
        {i_adp, i_bdp} = 2'b00; enc_idx = 0;
        repeat (12) @(negedge clk);
        n_total++; if (o_wheel_pos !== 32'd0) $display("FAIL jump_back_pos: got %0d want 0", o_wheel_pos); else n_pass++;
        n_total++; if (fall_q.size() - nf0 != 0) $display("FAIL jump_npulse: got %0d want 0", fall_q.size() - nf0); else n_pass++;
        enc_step(1'b1);
        n_total++; if (o_wheel_pos !== 32'd1) $display("FAIL jump_step_pos: got %0d want 1", o_wheel_pos); else n_pass++;
        n_total++; if (fall_q.size() - nf0 != 1) $display("FAIL jump_step_npulse: got %0d want 1", fall_q.size() - nf0); else n_pass++;
    endtask

    task automatic test_ext_sync();
        int nf0, t0, gap, s1, s2, got;
        do_reset();
        nf0 = fall_q.size();
        gap = $urandom_range(60, 150);
        s1  = $urandom_range(5, 15);
        s2  = $urandom_range(5, 15);
        cfg_min_gap = 24'(gap); cfg_mode = 2'd3;
        repeat (4) @(negedge clk);
        i_sync = 1'b1; t0 = cyc;
        repeat (3) @(negedge clk); i_sync = 1'b0;
        repeat (s1 - 3) @(negedge clk); i_sync = 1'b1;
        repeat (3) @(negedge clk); i_sync = 1'b0;
        repeat (s2 - 3) @(negedge clk); i_sync = 1'b1;
        repeat (3) @(negedge clk); i_sync = 1'b0;
        repeat (gap + 40) @(negedge clk);
        // Two sync stages plus edge detect, then pending, then PULSE
        got = (nf0 < fall_q.size()) ? fall_q[nf0] : -1;
        n_total++; if (got != t0 + 4) $display("FAIL ext_fall0: got %0d want %0d", got, t0 + 4); else n_pass++;
        got = (nf0 + 1 < fall_q.size()) ? fall_q[nf0 + 1] : -1;
        n_total++; if (got != t0 + 6 + gap) $display("FAIL ext_fall1: got %0d want %0d", got, t0 + 6 + gap); else n_pass++;
        n_total++; if (fall_q.size() - nf0 != 2) $display("FAIL ext_npulse: got %0d want 2", fall_q.size() - nf0); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd2) $display("FAIL ext_cnt: got %0d want 2", o_sync_cnt); else n_pass++;
        n_total++; if (o_overrun !== 1'b1) $display("FAIL ext_ovr: got %b want 1", o_overrun); else n_pass++;
        i_clr_ovr = 1'b1; @(negedge clk); i_clr_ovr = 1'b0;
        n_total++; if (o_overrun !== 1'b0) $display("FAIL ext_clr: got %b want 0", o_overrun); else n_pass++;
    endtask

    task automatic test_timeout();
        int nf0, t0, got;
        do_reset();
        nf0 = fall_q.size();
        cfg_period = 24'd200; i_chan_cmpl = 4'b0111; cfg_mode = 2'd1;
        t0 = cyc;
        repeat (200 + int'(TMO) + 40) @(negedge clk);
        got = (nf0 < fall_q.size()) ? fall_q[nf0] : -1;
        n_total++; if (got != t0 + 202) $display("FAIL tmo_fall0: got %0d want %0d", got, t0 + 202); else n_pass++;
        got = (nf0 + 1 < fall_q.size()) ? fall_q[nf0 + 1] : -1;
        n_total++; if (got != t0 + 208 + int'(TMO)) $display("FAIL tmo_fall1: got %0d want %0d", got, t0 + 208 + int'(TMO)); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd2) $display("FAIL tmo_cnt: got %0d want 2", o_sync_cnt); else n_pass++;
        n_total++; if (o_overrun !== 1'b1) $display("FAIL tmo_ovr: got %b want 1", o_overrun); else n_pass++;
        i_chan_cmpl = 4'hF; cfg_mode = 2'd0;
        repeat (10) @(negedge clk);
        n_total++; if (o_overrun !== 1'b1) $display("FAIL tmo_ovr_sticky: got %b want 1", o_overrun); else n_pass++;
        i_clr_ovr = 1'b1; @(negedge clk); i_clr_ovr = 1'b0;
        n_total++; if (o_overrun !== 1'b0) $display("FAIL tmo_clr: got %b want 0", o_overrun); else n_pass++;
    endtask

    task automatic test_reset_midpulse();
        int nf0, p, t0, budget, got;
        do_reset();
        for (int k = 0; k < 4; k++) enc_step(1'b1);
        n_total++; if (o_wheel_pos !== 32'd4) $display("FAIL mid_pos_pre: got %0d want 4", o_wheel_pos); else n_pass++;
        p = $urandom_range(40, 100);
        nf0 = fall_q.size();
        cfg_period = 24'(p); cfg_mode = 2'd1;
        budget = p + 20;
        while (fall_q.size() == nf0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_total++; if (fall_q.size() == nf0) $display("FAIL mid_wait: got no pulse within %0d cycles want one", p + 20); else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (o_msync_n !== 1'b1) $display("FAIL mid_msync: got %b want 1", o_msync_n); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", o_sync_cnt); else n_pass++;
        n_total++; if (o_wheel_pos !== 32'd0) $display("FAIL mid_pos: got %0d want 0", o_wheel_pos); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; t0 = cyc;
        nf0 = fall_q.size();
        repeat (p + 10) @(negedge clk);
        got = (nf0 < fall_q.size()) ? fall_q[nf0] : -1;
        n_total++; if (got != t0 + p + 2) $display("FAIL mid_restart: got %0d want %0d", got, t0 + p + 2); else n_pass++;
        n_total++; if (o_sync_cnt !== 16'd1) $display("FAIL mid_restart_cnt: got %0d want 1", o_sync_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        cfg_mode = 2'd0; cfg_period = '0; cfg_min_gap = '0;
        cfg_wheel_div = '0; cfg_wheel_dir = 1'b0;
        i_adp = 1'b0; i_bdp = 1'b0; i_sync = 1'b0;
        i_chan_cmpl = 4'hF; i_clr_ovr = 1'b0;
        enc_idx = 0; exp_pos = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_timer(1000, 5);
        test_timer($urandom_range(50, 300), 5);
        test_wheel_plan();
        test_wheel_random();
        test_illegal_jump();
        test_ext_sync();
        test_timeout();
        test_reset_midpulse();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
